// File: rtl/cordic_iter_ctrl.sv
// -----------------------------------------------------------------------------
// cordic_iter_ctrl
//
// Sequencing controller for the iterative CORDIC micro-rotation datapath.
// Takes one job per input handshake, pulses the datapath load, steps the
// datapath through N_ITER micro-rotations, and then holds the result valid
// until the consumer takes it.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. A producer that has raised valid keeps
// it and its payload stable until that edge. ready never depends on valid
// within the same cycle.
//
// Ports:
//   clk        system clock, all state changes on its rising edge
//   rst        synchronous active-high reset, aborts any running job
//   in_valid   job request
//   in_ready   controller can accept a job (IDLE only)
//   in_mode    0 = rotation, 1 = vectoring, sampled at accept
//   dp_load    one-cycle pulse: datapath loads x0/y0/z0
//   dp_en      datapath performs one micro-rotation this cycle
//   dp_iter    iteration index (shift amount / arctan LUT address)
//   dp_mode    mode latched for the current job
//   z_sign     sign bit of datapath z register
//   y_sign     sign bit of datapath y register
//   dp_dir     rotation direction, 1 = d=+1, 0 = d=-1 (0 when dp_en=0)
//   out_valid  datapath result is final
//   out_ready  consumer takes the result
//   busy       controller is in any state other than IDLE
//   dbg_state  current FSM state encoding (IDLE=0, LOAD=1, ITER=2, DONE=3)
// -----------------------------------------------------------------------------
module cordic_iter_ctrl #(
  parameter int N_ITER = 16,
  parameter int IW     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_mode,
  output logic          dp_load,
  output logic          dp_en,
  output logic [IW-1:0] dp_iter,
  output logic          dp_mode,
  input  logic          z_sign,
  input  logic          y_sign,
  output logic          dp_dir,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Final index of a job. With N_ITER = 2**IW this is all-ones, so the exit
  // is decided by this compare and the counter never has to wrap.
  localparam logic [IW-1:0] LAST_ITER = IW'(N_ITER - 1);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] iter_q, iter_d;
  logic          mode_q, mode_d;

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mode_d  = in_mode;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        iter_d  = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        if (iter_q == LAST_ITER) begin
          // Hold the last index through DONE rather than incrementing.
          state_d = S_DONE;
        end else begin
          iter_d = iter_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          iter_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        iter_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      mode_q  <= mode_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign dp_load   = (state_q == S_LOAD);
  assign dp_en     = (state_q == S_ITER);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign dp_iter   = iter_q;
  assign dp_mode   = mode_q;
  assign dbg_state = state_q;

  // Rotation drives z toward 0 (d=+1 while z>=0); vectoring drives y toward 0
  // (d=+1 while y<0). Forced low outside micro-rotation cycles.
  assign dp_dir = dp_en & (mode_q ? y_sign : ~z_sign);

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
module tb_cordic_iter_ctrl;
  localparam int N  = 16;
  localparam int IW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (N_ITER = 16) ----------------
  logic          in_valid = 0, in_mode = 0, out_ready = 1;
  logic          z_sign = 0, y_sign = 0;
  logic          in_ready, dp_load, dp_en, dp_mode, dp_dir, out_valid, busy;
  logic [IW-1:0] dp_iter;
  logic [1:0]    dbg_state;

  cordic_iter_ctrl #(.N_ITER(N), .IW(IW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .dp_load(dp_load), .dp_en(dp_en), .dp_iter(dp_iter),
    .dp_mode(dp_mode), .z_sign(z_sign), .y_sign(y_sign), .dp_dir(dp_dir),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- DUT (N_ITER = 1) ----------------
  logic          in_valid1 = 0, in_mode1 = 0, out_ready1 = 1;
  logic          in_ready1, dp_load1, dp_en1, dp_mode1, dp_dir1, out_valid1, busy1;
  logic [IW-1:0] dp_iter1;
  logic [1:0]    dbg_state1;

  cordic_iter_ctrl #(.N_ITER(1), .IW(IW)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_mode(in_mode1), .dp_load(dp_load1), .dp_en(dp_en1), .dp_iter(dp_iter1),
    .dp_mode(dp_mode1), .z_sign(z_sign), .y_sign(y_sign), .dp_dir(dp_dir1),
    .out_valid(out_valid1), .out_ready(out_ready1), .busy(busy1),
    .dbg_state(dbg_state1)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // dp_dir vectors: {mode, z_sign, y_sign, expected dp_dir}
  typedef struct {
    logic mode;
    logic z;
    logic y;
    logic exp_dir;
  } dir_vec_t;
  dir_vec_t tbl[8];

  // ---------------- scoreboard ----------------
  bit            mon_en     = 0;
  bit            job_active = 0;
  logic          cur_mode   = 0;
  int            load_cyc   = -1;
  int            done_cyc   = -1;
  int            acc_cnt    = 0;
  int            last_acc   = -1;
  int            prev_acc   = -1;
  int            hs_cyc     = -1;
  logic [IW-1:0] exp_q[$];

  // A sampled reset discards whatever job the model was tracking.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      job_active = 0;
    end
  end

  always @(negedge clk) begin : mon
    logic [IW-1:0] e;
    logic          ed;
    if (mon_en) begin
      check("ready_vs_busy", in_ready, !busy);
      check("dp_load", dp_load, job_active && (cyc == load_cyc));
      check("out_valid", out_valid, job_active && (cyc >= done_cyc));
      if (dp_en) begin
        if (exp_q.size() == 0) begin
          check("dp_en_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("dp_iter", dp_iter, e);
        end
        ed = cur_mode ? y_sign : ~z_sign;
        check("dp_dir", dp_dir, ed);
        check("dp_mode", dp_mode, cur_mode);
      end else begin
        check("dp_dir_off", dp_dir, 0);
      end
      if (out_valid && out_ready) begin
        job_active = 0;
        hs_cyc     = cyc;
      end
      if (in_valid && in_ready) begin
        for (int i = 0; i < N; i++) exp_q.push_back(IW'(i));
        cur_mode   = in_mode;
        job_active = 1;
        load_cyc   = cyc + 1;
        done_cyc   = cyc + N + 2;
        prev_acc   = last_acc;
        last_acc   = cyc;
        acc_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    z_sign = 1'($urandom_range(0, 1));
    y_sign = 1'($urandom_range(0, 1));
  endtask

  // One job on the N=16 DUT; dp_dir inputs come from the vector table and the
  // result is held back for 'stall' cycles in DONE.
  task automatic run_job(input logic mode, input int stall);
    int k;
    int w;
    int idx;
    dir_vec_t v;
    step();
    in_valid  = 1;
    in_mode   = mode;
    out_ready = (stall == 0);
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 40) begin
      step();
      @(negedge clk);
      w++;
    end
    check("accept_timeout", w < 40, 1);
    step();
    in_valid = 0;
    in_mode  = ~mode;
    k = 0;
    w = 0;
    while (w < N + 10) begin
      idx    = (mode ? 4 : 0) + (k % 4);
      v      = tbl[idx];
      z_sign = v.z;
      y_sign = v.y;
      @(negedge clk);
      if (dp_en) begin
        check("tbl_dir", dp_dir, v.exp_dir);
        k++;
      end
      if (out_valid) break;
      step();
      w++;
    end
    check("iter_count", k, N);
    check("done_reached", out_valid, 1);
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", out_valid, 1);
      check("stall_en", dp_en, 0);
      check("stall_iter", dp_iter, N - 1);
      check("stall_ready", in_ready, 0);
      step();
      if (s == stall - 1) out_ready = 1;
      @(negedge clk);
    end
    check("hs_valid", out_valid, 1);
    step();
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_ready", in_ready, 1);
    check("idle_iter", dp_iter, 0);
    check("idle_valid", out_valid, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int w;
    int a0;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

    // Reset state
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_dp_load", dp_load, 0);
    check("rst_dp_en", dp_en, 0);
    check("rst_dp_dir", dp_dir, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_dp_iter", dp_iter, 0);
    check("rst_dp_mode", dp_mode, 0);
    check("rst_state", dbg_state, 0);
    check("rst1_in_ready", in_ready1, 1);
    check("rst1_busy", busy1, 0);
    step();
    rst    = 0;
    mon_en = 1;

    // N_ITER = 1 corner: single dp_en cycle, out_valid at accept+3
    step();
    in_valid1 = 1;
    in_mode1  = 0;
    @(negedge clk);
    check("n1_accept", in_ready1, 1);
    step();
    in_valid1 = 0;
    in_mode1  = 1;
    @(negedge clk);
    check("n1_load", dp_load1, 1);
    check("n1_load_en", dp_en1, 0);
    step();
    z_sign = 0;
    @(negedge clk);
    check("n1_en", dp_en1, 1);
    check("n1_iter", dp_iter1, 0);
    check("n1_dir", dp_dir1, 1);
    check("n1_mode", dp_mode1, 0);
    step();
    @(negedge clk);
    check("n1_en_off", dp_en1, 0);
    check("n1_out_valid", out_valid1, 1);
    check("n1_iter_hold", dp_iter1, 0);
    step();
    @(negedge clk);
    check("n1_idle_valid", out_valid1, 0);
    check("n1_idle_ready", in_ready1, 1);
    check("n1_idle_busy", busy1, 0);

    // Rotation job, no backpressure; vectoring job with 5 stall cycles
    run_job(1'b0, 0);
    run_job(1'b1, 5);

    // Back-to-back with in_valid held high
    step();
    in_valid  = 1;
    in_mode   = 1;
    out_ready = 1;
    a0 = acc_cnt;
    w  = 0;
    while (acc_cnt < a0 + 2 && w < 100) begin
      step();
      w++;
    end
    check("b2b_two_accepts", acc_cnt, a0 + 2);
    check("b2b_accept_after_hs", last_acc, hs_cyc + 1);
    check("b2b_spacing", last_acc - prev_acc, N + 3);
    in_valid = 0;
    in_mode  = 0;
    w = 0;
    @(negedge clk);
    while (busy && w < 60) begin
      step();
      @(negedge clk);
      w++;
    end
    check("b2b_drain", busy, 0);

    // Reset mid-job at dp_iter = 7
    step();
    in_valid = 1;
    in_mode  = 0;
    @(negedge clk);
    step();
    in_valid = 0;
    w = 0;
    @(negedge clk);
    while (!(dp_en && dp_iter == 7) && w < 40) begin
      step();
      @(negedge clk);
      w++;
    end
    check("abort_reach_iter7", w < 40, 1);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check("abort_dp_en", dp_en, 0);
    check("abort_dp_iter", dp_iter, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    repeat (25) step();

    // Recovery and a few random jobs
    run_job(1'b0, 2);
    for (int j = 0; j < 4; j++) begin
      run_job(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    step();
    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/cordic_iter_ctrl.md
Name: cordic_iter_ctrl

Overview:
- Sequencing controller for the team's iterative CORDIC micro-rotation datapath.
- Accepts one job per valid/ready handshake, pulses the datapath load and steps it through N_ITER micro-rotations.
- Drives the iteration index used for the shift amount and arctan LUT address, and selects the rotation direction each iteration from datapath sign feedback.
- Presents completion on an output valid/ready handshake with backpressure. Sits between the request source and the x/y/z datapath registers.

Parameters:
- N_ITER, 16, number of micro-rotations per job; legal range 1..2^IW.
- IW, 4, width of the iteration index.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  job request.
- in_ready  output  1  controller can accept a job.
- in_mode  input  1  0 = rotation, 1 = vectoring; sampled at accept.
- dp_load  output  1  one-cycle pulse: datapath loads x0/y0/z0.
- dp_en  output  1  datapath performs one micro-rotation this cycle.
- dp_iter  output  IW  current iteration index (shift amount / LUT address).
- dp_mode  output  1  latched mode of the current job.
- z_sign  input  1  sign bit of the datapath z register.
- y_sign  input  1  sign bit of the datapath y register.
- dp_dir  output  1  1 = d=+1, 0 = d=-1.
- out_valid  output  1  datapath result is final.
- out_ready  input  1  consumer takes the result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, LOAD, ITER, DONE.
- Reset (rst=1 at an edge) forces IDLE, dp_iter=0, dp_mode=0 and the internal counter to 0. Outputs after reset: in_ready=1, dp_load=0, dp_en=0, dp_dir=0, out_valid=0, busy=0.
- Reset has priority over every other input and aborts any job mid-operation. dp_en is low from the first cycle after the reset edge. The aborted job produces no out_valid.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch in_mode into dp_mode and go to LOAD.
  - in_valid while not in IDLE is ignored and not accepted (in_ready=0).
- LOAD:
  - dp_load=1 for exactly one cycle, dp_iter=0.
  - Next state is ITER.
- ITER:
  - dp_en=1 every cycle. dp_iter counts 0,1,...,N_ITER-1, one per cycle.
  - After the cycle with dp_iter=N_ITER-1, go to DONE.
  - dp_iter does not wrap inside a job. With N_ITER=2^IW the final index is all-ones, and the exit is decided by the compare, not by overflow.
- dp_dir:
  - Combinational, valid only while dp_en=1; 0 otherwise.
  - Rotation mode: dp_dir = ~z_sign (z>=0 gives d=+1).
  - Vectoring mode: dp_dir = y_sign (y<0 gives d=+1).
- DONE:
  - out_valid=1, held stable with dp_en=0 until out_ready=1.
  - On out_valid & out_ready: go to IDLE, out_valid drops next cycle, dp_iter returns to 0.
  - out_ready asserted before DONE has no effect.
- Latency: accept at edge t gives dp_load high in cycle t+1, dp_en high in cycles t+2..t+N_ITER+1, and out_valid high from cycle t+N_ITER+2.
- Throughput: one job per N_ITER+3 cycles minimum, since IDLE costs one cycle after the output handshake.
- Simultaneous events:
  - out_ready and in_valid in the same DONE cycle: result is consumed, the new job is not accepted that cycle (in_ready=0) and is accepted in the following IDLE cycle.
- busy = (state != IDLE).
- in_mode changes after accept do not affect the running job.

Test Plan:
- Reset, then in_valid=1, in_mode=0, with N_ITER=16 and out_ready=1 -> dp_load one cycle after accept, dp_en for 16 cycles with dp_iter 0..15, out_valid exactly 18 cycles after the accept edge for 1 cycle.
- Rotation mode: drive z_sign=0 at iteration 3 and z_sign=1 at iteration 4 -> dp_dir=1 then 0. Vectoring mode: y_sign=1 -> dp_dir=1. dp_dir=0 in LOAD and DONE.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, dp_en stays 0, dp_iter stable, in_ready=0. Release -> IDLE next cycle.
- Back-to-back: in_valid held high continuously -> second accept occurs exactly one cycle after the first out handshake, and in_valid is never accepted while busy=1.
- Reset mid-job: assert rst at dp_iter=7 -> next cycle IDLE, dp_en=0, dp_iter=0, in_ready=1, and no out_valid for the aborted job.
- Parameter corners: N_ITER=1 -> one dp_en cycle with dp_iter=0, out_valid at accept+3. N_ITER=16 with IW=4 -> exits after index 15 with no wrap to 0.
